nap_countdown: RTL and testbench

//  Countdown stage directly downstream of the nap-time setting FSM. On `load` (driven by the setter's
//  `complete` pulse) captures the six BCD time digits, decrements once per second to 00:00:00, then

---
 rtl/nap_pkg.sv | 29 ++
 rtl/bcd_digit_down.sv | 45 ++++
 rtl/nap_countdown.sv | 195 +++++++++++++++++++
 tb/tb_nap_countdown.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/nap_pkg.sv
// Shared types and constants for the nap-time countdown stage:
// FSM state encoding, BCD digit width and per-digit maxima.
package nap_pkg;

    localparam int BCD_W = 4;

    localparam logic [BCD_W-1:0] MAX_NINE = 4'd9;
    localparam logic [BCD_W-1:0] MAX_FIVE = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } nap_state_t;

    // Clamp an out-of-range BCD digit to the largest legal value for its position.
    function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] v,
                                                 input logic [BCD_W-1:0] max_v);
        logic [BCD_W-1:0] r;
        if (v > max_v) begin
            r = max_v;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit. A decrement at zero reloads MAX and
// raises borrow_out so the next-higher digit decrements in the same cycle.
module bcd_digit_down
    import nap_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX = 4'd9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    input  logic             dec,
    output logic [BCD_W-1:0] value,
    output logic             borrow_out
);

    logic [BCD_W-1:0] value_nx;

    assign borrow_out = dec && (value == 4'd0);

    // Next digit value: clear beats load beats decrement.
    always_comb begin
        value_nx = value;
        if (clr) begin
            value_nx = 4'd0;
        end else if (load) begin
            value_nx = load_val;
        end else if (dec) begin
            value_nx = (value == 4'd0) ? MAX : (value - 4'd1);
        end else begin
            value_nx = value;
        end
    end

    // Digit register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= 4'd0;
        end else begin
            value <= value_nx;
        end
    end

endmodule

// File: rtl/nap_countdown.sv
// Nap countdown: captures a BCD hh:mm:ss value on load, counts down once per
// CLK_DIV clocks, then holds the wake-up alarm for ALARM_SEC seconds.
module nap_countdown
    import nap_pkg::*;
#(
    parameter int CLK_DIV   = 50_000_000,
    parameter int ALARM_SEC = 30
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [BCD_W-1:0] iHour10,
    input  logic [BCD_W-1:0] iHour1,
    input  logic [BCD_W-1:0] iMinute10,
    input  logic [BCD_W-1:0] iMinute1,
    input  logic [BCD_W-1:0] iSecond10,
    input  logic [BCD_W-1:0] iSecond1,
    input  logic             pause,
    input  logic             cancel,
    output logic [BCD_W-1:0] hour10,
    output logic [BCD_W-1:0] hour1,
    output logic [BCD_W-1:0] minute10,
    output logic [BCD_W-1:0] minute1,
    output logic [BCD_W-1:0] second10,
    output logic [BCD_W-1:0] second1,
    output logic             running,
    output logic             paused,
    output logic             alarm,
    output logic             done
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int AW = $clog2(ALARM_SEC + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SEC - 1);

    nap_state_t    state_r;
    nap_state_t    state_nx;
    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_nx;
    logic [AW-1:0] acnt_r;
    logic [AW-1:0] acnt_nx;
    logic          done_nx;

    logic          dig_clr_s;
    logic          dig_load_s;
    logic          dig_dec_s;
    logic [6:0]    borrow_s;

    logic [BCD_W-1:0] sat_h10_s, sat_h1_s, sat_m10_s, sat_m1_s, sat_s10_s, sat_s1_s;
    logic             load_zero_s;
    logic             zero_s;
    logic             one_s;
    logic             wrap_s;

    assign sat_h10_s = bcd_sat(iHour10,   MAX_NINE);
    assign sat_h1_s  = bcd_sat(iHour1,    MAX_NINE);
    assign sat_m10_s = bcd_sat(iMinute10, MAX_FIVE);
    assign sat_m1_s  = bcd_sat(iMinute1,  MAX_NINE);
    assign sat_s10_s = bcd_sat(iSecond10, MAX_FIVE);
    assign sat_s1_s  = bcd_sat(iSecond1,  MAX_NINE);

    // Saturation never turns a nonzero digit into zero, so the raw inputs suffice here.
    assign load_zero_s = ({iHour10, iHour1, iMinute10, iMinute1, iSecond10, iSecond1} == 24'd0);
    assign zero_s = ({hour10, hour1, minute10, minute1, second10, second1} == 24'd0);
    assign one_s  = ({hour10, hour1, minute10, minute1, second10, second1} == 24'h00_00_01);
    assign wrap_s = (presc_r == PRESC_LAST);

    // Next-state, prescaler, alarm counter and digit controls; cancel > load > pause > tick.
    always_comb begin
        state_nx   = state_r;
        presc_nx   = presc_r;
        acnt_nx    = acnt_r;
        done_nx    = 1'b0;
        dig_clr_s  = 1'b0;
        dig_load_s = 1'b0;
        dig_dec_s  = 1'b0;
        if (cancel) begin
            state_nx  = ST_IDLE;
            presc_nx  = {PW{1'b0}};
            acnt_nx   = {AW{1'b0}};
            dig_clr_s = 1'b1;
        end else if (load) begin
            presc_nx = {PW{1'b0}};
            acnt_nx  = {AW{1'b0}};
            if (load_zero_s) begin
                state_nx  = ST_IDLE;
                dig_clr_s = 1'b1;
            end else begin
                state_nx   = ST_RUN;
                dig_load_s = 1'b1;
            end
        end else if (pause && (state_r != ST_IDLE)) begin
            case (state_r)
                ST_RUN:   state_nx = ST_PAUSE;
                ST_PAUSE: state_nx = ST_RUN;
                ST_ALARM: begin
                    state_nx = ST_IDLE;
                    presc_nx = {PW{1'b0}};
                    acnt_nx  = {AW{1'b0}};
                end
                default:  state_nx = ST_IDLE;
            endcase
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (wrap_s) begin
                        presc_nx  = {PW{1'b0}};
                        dig_dec_s = !zero_s;
                        if (one_s) begin
                            state_nx = ST_ALARM;
                            done_nx  = 1'b1;
                            acnt_nx  = {AW{1'b0}};
                        end else begin
                            state_nx = ST_RUN;
                        end
                    end else begin
                        presc_nx = presc_r + {{(PW-1){1'b0}}, 1'b1};
                    end
                end
                ST_ALARM: begin
                    if (wrap_s) begin
                        presc_nx = {PW{1'b0}};
                        if (acnt_r == ALARM_LAST) begin
                            state_nx = ST_IDLE;
                            acnt_nx  = {AW{1'b0}};
                        end else begin
                            acnt_nx = acnt_r + {{(AW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        presc_nx = presc_r + {{(PW-1){1'b0}}, 1'b1};
                    end
                end
                ST_IDLE:  presc_nx = {PW{1'b0}};
                ST_PAUSE: presc_nx = presc_r;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    // State, counters and registered status flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            presc_r <= {PW{1'b0}};
            acnt_r  <= {AW{1'b0}};
            running <= 1'b0;
            paused  <= 1'b0;
            alarm   <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_nx;
            presc_r <= presc_nx;
            acnt_r  <= acnt_nx;
            running <= (state_nx == ST_RUN);
            paused  <= (state_nx == ST_PAUSE);
            alarm   <= (state_nx == ST_ALARM);
            // An hour10 borrow would mean wrapping below zero; never report that as done.
            done    <= done_nx && !borrow_s[6];
        end
    end

    assign borrow_s[0] = dig_dec_s;

    bcd_digit_down #(.MAX(MAX_NINE)) u_second1 (
        .clock(clock), .reset(reset), .clr(dig_clr_s), .load(dig_load_s),
        .load_val(sat_s1_s), .dec(borrow_s[0]), .value(second1), .borrow_out(borrow_s[1])
    );

    bcd_digit_down #(.MAX(MAX_FIVE)) u_second10 (
        .clock(clock), .reset(reset), .clr(dig_clr_s), .load(dig_load_s),
        .load_val(sat_s10_s), .dec(borrow_s[1]), .value(second10), .borrow_out(borrow_s[2])
    );

    bcd_digit_down #(.MAX(MAX_NINE)) u_minute1 (
        .clock(clock), .reset(reset), .clr(dig_clr_s), .load(dig_load_s),
        .load_val(sat_m1_s), .dec(borrow_s[2]), .value(minute1), .borrow_out(borrow_s[3])
    );

    bcd_digit_down #(.MAX(MAX_FIVE)) u_minute10 (
        .clock(clock), .reset(reset), .clr(dig_clr_s), .load(dig_load_s),
        .load_val(sat_m10_s), .dec(borrow_s[3]), .value(minute10), .borrow_out(borrow_s[4])
    );

    bcd_digit_down #(.MAX(MAX_NINE)) u_hour1 (
        .clock(clock), .reset(reset), .clr(dig_clr_s), .load(dig_load_s),
        .load_val(sat_h1_s), .dec(borrow_s[4]), .value(hour1), .borrow_out(borrow_s[5])
    );

    bcd_digit_down #(.MAX(MAX_NINE)) u_hour10 (
        .clock(clock), .reset(reset), .clr(dig_clr_s), .load(dig_load_s),
        .load_val(sat_h10_s), .dec(borrow_s[5]), .value(hour10), .borrow_out(borrow_s[6])
    );

endmodule

// File: tb/tb_nap_countdown.sv
// Self-checking bench for nap_countdown: directed scenarios plus random strobes,
// compared every cycle against a seconds-based reference model.
module tb_nap_countdown;

    localparam int CLK_DIV   = 4;
    localparam int ALARM_SEC = 3;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_ALARM = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0, pause = 1'b0, cancel = 1'b0;
    logic [3:0] iHour10 = 4'd0, iHour1 = 4'd0, iMinute10 = 4'd0;
    logic [3:0] iMinute1 = 4'd0, iSecond10 = 4'd0, iSecond1 = 4'd0;
    logic [3:0] hour10, hour1, minute10, minute1, second10, second1;
    logic       running, paused, alarm, done;

    int checks = 0;
    int errors = 0;

    // reference model: remaining time in whole seconds plus phase within the current second
    int m_st    = M_IDLE;
    int m_secs  = 0;
    int m_phase = 0;
    int m_acnt  = 0;
    int m_done  = 0;

    nap_countdown #(.CLK_DIV(CLK_DIV), .ALARM_SEC(ALARM_SEC)) dut (
        .clock(clock), .reset(reset), .load(load),
        .iHour10(iHour10), .iHour1(iHour1), .iMinute10(iMinute10),
        .iMinute1(iMinute1), .iSecond10(iSecond10), .iSecond1(iSecond1),
        .pause(pause), .cancel(cancel),
        .hour10(hour10), .hour1(hour1), .minute10(minute10),
        .minute1(minute1), .second10(second10), .second1(second1),
        .running(running), .paused(paused), .alarm(alarm), .done(done)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clampd(input logic [3:0] v, input int mx);
        return (int'(v) > mx) ? mx : int'(v);
    endfunction

    function automatic logic [23:0] exp_digits(input int secs);
        int h, m, s;
        h = secs / 3600;
        m = (secs / 60) % 60;
        s = secs % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_step(input logic ld, input logic pa, input logic ca, input logic [23:0] d);
        int t;
        m_done = 0;
        if (ca) begin
            m_st = M_IDLE; m_secs = 0; m_phase = 0; m_acnt = 0;
        end else if (ld) begin
            t = (clampd(d[23:20], 9) * 10 + clampd(d[19:16], 9)) * 3600
              + (clampd(d[15:12], 5) * 10 + clampd(d[11:8], 9)) * 60
              + clampd(d[7:4], 5) * 10 + clampd(d[3:0], 9);
            m_secs = t; m_phase = 0; m_acnt = 0;
            m_st = (t == 0) ? M_IDLE : M_RUN;
        end else if (pa && m_st != M_IDLE) begin
            if (m_st == M_RUN) m_st = M_PAUSE;
            else if (m_st == M_PAUSE) m_st = M_RUN;
            else begin m_st = M_IDLE; m_phase = 0; m_acnt = 0; end
        end else if (m_st == M_RUN || m_st == M_ALARM) begin
            m_phase++;
            if (m_phase == CLK_DIV) begin
                m_phase = 0;
                if (m_st == M_RUN) begin
                    m_secs--;
                    if (m_secs == 0) begin m_st = M_ALARM; m_done = 1; m_acnt = 0; end
                end else begin
                    m_acnt++;
                    if (m_acnt == ALARM_SEC) begin m_st = M_IDLE; m_acnt = 0; end
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".digits"}, {8'd0, hour10, hour1, minute10, minute1, second10, second1},
                  {8'd0, exp_digits(m_secs)});
        check_val({tag, ".flags"}, {28'd0, running, paused, alarm, done},
                  {28'd0, m_st == M_RUN, m_st == M_PAUSE, m_st == M_ALARM, m_done != 0});
    endtask

    task automatic cycle(input string tag, input logic ld, input logic pa, input logic ca,
                         input logic [23:0] d);
        @(negedge clock);
        load = ld; pause = pa; cancel = ca;
        {iHour10, iHour1, iMinute10, iMinute1, iSecond10, iSecond1} = d;
        model_step(ld, pa, ca, d);
        @(posedge clock);
        #1;
        load = 1'b0; pause = 1'b0; cancel = 1'b0;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b0, 1'b0, 24'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        reset = 1'b1;
        #1;
        m_st = M_IDLE; m_secs = 0; m_phase = 0; m_acnt = 0; m_done = 0;
        check_outputs(tag);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic [23:0] d;
        int r;
        do_reset("reset");

        // 1: short countdown through alarm and auto-return
        cycle("s1.load", 1'b1, 1'b0, 1'b0, 24'h00_00_05);
        idle("s1.run", 40);
        // 2: full borrow chain
        cycle("s2.load", 1'b1, 1'b0, 1'b0, 24'h01_00_00);
        idle("s2.run", 10);
        // 3: pause mid-second, hold, resume
        cycle("s3.load", 1'b1, 1'b0, 1'b0, 24'h00_01_00);
        idle("s3.run", 9);
        cycle("s3.pause", 1'b0, 1'b1, 1'b0, 24'd0);
        idle("s3.hold", 20);
        cycle("s3.resume", 1'b0, 1'b1, 1'b0, 24'd0);
        idle("s3.run2", 10);
        // 4: load+cancel together, zero load, pause in idle
        cycle("s4.ldcan", 1'b1, 1'b0, 1'b1, 24'h00_00_09);
        cycle("s4.zero", 1'b1, 1'b0, 1'b0, 24'h00_00_00);
        cycle("s4.pidle", 1'b0, 1'b1, 1'b0, 24'd0);
        idle("s4.idle", 3);
        // 5: saturation, then restart mid-run, then out-of-range everything
        cycle("s5.sat", 1'b1, 1'b0, 1'b0, 24'h00_07_0F);
        idle("s5.run", 6);
        cycle("s5.reload", 1'b1, 1'b0, 1'b0, 24'h00_00_30);
        idle("s5.run2", 6);
        cycle("s5.allsat", 1'b1, 1'b0, 1'b0, 24'hFF_FF_FF);
        idle("s5.run3", 5);
        // 6: reset mid-run, reset in alarm, pause acknowledges alarm
        do_reset("s6.rstrun");
        cycle("s6.load", 1'b1, 1'b0, 1'b0, 24'h00_00_01);
        idle("s6.toalarm", 6);
        do_reset("s6.rstalarm");
        cycle("s6.load2", 1'b1, 1'b0, 1'b0, 24'h00_00_01);
        idle("s6.toalarm2", 6);
        cycle("s6.ack", 1'b0, 1'b1, 1'b0, 24'd0);
        idle("s6.after", 3);

        // random strobes and values
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 199);
            case ($urandom_range(0, 3))
                0:       d = {20'd0, 4'($urandom_range(0, 15))};
                1:       d = {16'd0, 4'($urandom_range(0, 6)), 4'($urandom_range(0, 15))};
                2:       d = {12'd0, 4'($urandom_range(0, 1)), 8'($urandom)};
                default: d = 24'($urandom);
            endcase
            if (r == 0) do_reset("rnd.reset");
            else cycle("rnd", r < 8, (r >= 8) && (r < 18), (r >= 18) && (r < 21), d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
